// File: rtl/ppu_timing_gen_if.sv
// Timing bus between the PPU timing generator and the PPU/CPU logic it serves.
// master: the timing generator. slave: downstream consumers plus control sources.
interface ppu_timing_gen_if;
  logic       pll_locked;
  logic       rendering_en;
  logic       nmi_en;
  logic       vblank_clr;
  logic       sys_rst;
  logic [8:0] dot;
  logic [8:0] scanline;
  logic       cpu_ce;
  logic       vblank;
  logic       nmi_n;
  logic       frame_odd;
  logic       frame_start;

  modport master (
    input  pll_locked, rendering_en, nmi_en, vblank_clr,
    output sys_rst, dot, scanline, cpu_ce, vblank, nmi_n, frame_odd, frame_start
  );

  modport slave (
    output pll_locked, rendering_en, nmi_en, vblank_clr,
    input  sys_rst, dot, scanline, cpu_ce, vblank, nmi_n, frame_odd, frame_start
  );
endinterface

// File: rtl/ppu_timing_gen.sv
// NES NTSC PPU timing generator: PLL lock qualification into sys_rst, dot and
// scanline counters with the odd-frame dot skip, CPU clock enable, vblank and NMI.
module ppu_timing_gen #(
  parameter int LOCK_HOLD       = 16,
  parameter int CPU_DIV         = 3,
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input logic              clk,
  input logic              rst,
  ppu_timing_gen_if.master bus
);
  localparam logic [7:0] HOLD_MAX  = 8'(LOCK_HOLD);
  localparam logic [3:0] DIV_LAST  = 4'(CPU_DIV - 1);
  localparam logic [3:0] DIV_PRE   = 4'(CPU_DIV - 2);
  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_SKIP  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

  logic       sync1, sync2;
  logic [7:0] hold;
  logic       sys_rst_q;
  logic [3:0] div;
  logic [8:0] dot_q, line_q, dot_n, line_n;
  logic       odd_q, odd_n;
  logic       vbl_q, ce_q, fs_q;
  logic       skip;

  // Lock synchroniser and hold counter; sys_rst releases once the hold saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hold      <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      sync1 <= bus.pll_locked;
      sync2 <= sync1;
      if (!sync2)
        hold <= '0;
      else if (hold != HOLD_MAX)
        hold <= hold + 8'd1;
      sys_rst_q <= (hold != HOLD_MAX);
    end
  end

  // Next counter position; the odd-frame skip jumps from the second-to-last
  // dot of the pre-render line straight to the top of the next frame.
  always_comb begin
    skip   = odd_q && bus.rendering_en && (line_q == PRE_LINE) && (dot_q == DOT_SKIP);
    dot_n  = dot_q + 9'd1;
    line_n = line_q;
    odd_n  = odd_q;
    if (skip) begin
      dot_n  = '0;
      line_n = '0;
      odd_n  = ~odd_q;
    end else if (dot_q == DOT_LAST) begin
      dot_n = '0;
      if (line_q == LINE_LAST) begin
        line_n = '0;
        odd_n  = ~odd_q;
      end else begin
        line_n = line_q + 9'd1;
      end
    end
  end

  // Timing state; held in reset by rst or by the qualified sys_rst. Outputs that
  // describe a counter position are computed from the next position so they line
  // up with the counters in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || sys_rst_q) begin
      dot_q  <= '0;
      line_q <= '0;
      odd_q  <= 1'b0;
      div    <= '0;
      ce_q   <= 1'b0;
      fs_q   <= 1'b0;
      vbl_q  <= 1'b0;
    end else begin
      dot_q  <= dot_n;
      line_q <= line_n;
      odd_q  <= odd_n;
      div    <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
      ce_q   <= (div == DIV_PRE);
      fs_q   <= (dot_n == 9'd0) && (line_n == 9'd0);
      // Set beats both the scheduled clear and a coincident CPU status read.
      if (dot_n == 9'd1 && line_n == VBL_LINE)
        vbl_q <= 1'b1;
      else if (dot_n == 9'd1 && line_n == PRE_LINE)
        vbl_q <= 1'b0;
      else if (bus.vblank_clr)
        vbl_q <= 1'b0;
    end
  end

  assign bus.sys_rst     = sys_rst_q;
  assign bus.dot         = dot_q;
  assign bus.scanline    = line_q;
  assign bus.cpu_ce      = ce_q;
  assign bus.vblank      = vbl_q;
  assign bus.frame_odd   = odd_q;
  assign bus.frame_start = fs_q;
  assign bus.nmi_n       = !(vbl_q && bus.nmi_en);
endmodule
